// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles the requester side, the shared ALU side and the response side
//   of alu_share_arbiter.
//   slave  : the arbiter's view (requests, c_in and rsp_ready in;
//            grants, ALU operands, response and status out).
//   master : the surrounding environment's view (directions reversed).
//   Operands are packed 8 bits per requester, requester i at [8i+7:8i].
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [8*NUM_REQ-1:0] req_mode;
   logic [NUM_REQ-1:0]   req_ready;

   logic [7:0]           a_out;
   logic [7:0]           b_out;
   logic [7:0]           mode_out;
   logic [7:0]           c_in;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_data;
   logic                 rsp_err;

   logic                 busy;
   logic [CNT_W-1:0]     txn_count;

   modport slave (
      input  req_valid, req_a, req_b, req_mode, c_in, rsp_ready,
      output req_ready, a_out, b_out, mode_out,
      output rsp_valid, rsp_id, rsp_data, rsp_err, busy, txn_count
   );

   modport master (
      output req_valid, req_a, req_b, req_mode, c_in, rsp_ready,
      input  req_ready, a_out, b_out, mode_out,
      input  rsp_valid, rsp_id, rsp_data, rsp_err, busy, txn_count
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 8-bit a/b/mode -> c ALU among NUM_REQ requesters with
//   round-robin arbitration, one transaction in flight at a time.
//   Ports:
//     emu_clk   : clock, rising edge
//     emu_rst_n : synchronous active-low reset
//     bus       : alu_share_arbiter_if.slave (requests, ALU operands,
//                 c_in, tagged response, busy, txn_count)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | arbitrate; grant and latch winner's operands same cycle
//   S_WAIT | ALU settling; down-counter, capture c_in at terminal count
//   S_RESP | response held until rsp_ready, then count and return
module alu_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ALU_LAT  = 2,
   parameter int MAX_MODE = 8,
   parameter int CNT_W    = 16
) (
   input  logic             emu_clk,
   input  logic             emu_rst_n,
   alu_share_arbiter_if.slave bus
);
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t               state, state_nxt;
   logic [ID_W-1:0]      last;
   logic [WAIT_W-1:0]    wait_cnt;

   logic [7:0]           a_arr    [NUM_REQ];
   logic [7:0]           b_arr    [NUM_REQ];
   logic [7:0]           m_arr    [NUM_REQ];
   logic [NUM_REQ-1:0]   upper_valid;
   logic [NUM_REQ-1:0]   cand;
   logic [NUM_REQ-1:0]   grant_oh;
   logic [NUM_REQ-1:0]   id_terms [ID_W];
   logic [ID_W-1:0]      win_id;
   logic                 accept;
   logic                 mode_ok;

   // Round-robin: requesters above 'last' take precedence; if none of
   // them is valid, wrap around to the lowest valid index.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign a_arr[g]       = bus.req_a[8*g +: 8];
      assign b_arr[g]       = bus.req_b[8*g +: 8];
      assign m_arr[g]       = bus.req_mode[8*g +: 8];
      assign upper_valid[g] = bus.req_valid[g] && (ID_W'(g) > last);
   end

   assign cand     = (|upper_valid) ? upper_valid : bus.req_valid;
   assign grant_oh = cand & (~cand + NUM_REQ'(1));

   // One-hot to index encoder.
   for (genvar b = 0; b < ID_W; b++) begin : g_enc_bit
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_enc_req
         if (((g >> b) & 1) != 0) begin : g_set
            assign id_terms[b][g] = grant_oh[g];
         end else begin : g_clr
            assign id_terms[b][g] = 1'b0;
         end
      end
      assign win_id[b] = |id_terms[b];
   end

   assign mode_ok = (m_arr[win_id] <= 8'(MAX_MODE));

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      bus.req_ready = '0;
      bus.rsp_valid = (state == S_RESP);
      bus.busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            // Reset held low must not let a handshake complete.
            if (emu_rst_n && (|bus.req_valid)) begin
               accept        = 1'b1;
               bus.req_ready = grant_oh;
               state_nxt     = mode_ok ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (wait_cnt == '0) state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge emu_clk) begin
      if (!emu_rst_n) state <= S_IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge emu_clk) begin
      if (!emu_rst_n) begin
         last          <= ID_W'(NUM_REQ - 1);
         wait_cnt      <= '0;
         bus.a_out     <= '0;
         bus.b_out     <= '0;
         bus.mode_out  <= '0;
         bus.rsp_id    <= '0;
         bus.rsp_data  <= '0;
         bus.rsp_err   <= 1'b0;
         bus.txn_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  last       <= win_id;
                  bus.rsp_id <= win_id;
                  if (mode_ok) begin
                     bus.a_out    <= a_arr[win_id];
                     bus.b_out    <= b_arr[win_id];
                     bus.mode_out <= m_arr[win_id];
                     wait_cnt     <= WAIT_W'(ALU_LAT - 1);
                  end else begin
                     // ALU is left untouched on a rejected mode.
                     bus.rsp_err  <= 1'b1;
                     bus.rsp_data <= '0;
                  end
               end
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == '0) begin
                  bus.rsp_data <= bus.c_in;
                  bus.rsp_err  <= 1'b0;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) bus.txn_count <= bus.txn_count + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Drives alu_share_arbiter through directed scenarios followed by random
//   traffic, with a stand-in ALU that only produces a valid c after its
//   inputs have been stable for ALU_LAT cycles. A transaction-level model
//   predicts grants, response timing and contents every cycle.
module tb_alu_share_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int ALU_LAT  = 2;
   localparam int MAX_MODE = 8;
   localparam int CNT_W    = 4;
   localparam int VW       = 8 * NUM_REQ;

   logic emu_clk   = 1'b0;
   logic emu_rst_n = 1'b0;
   always #5 emu_clk = ~emu_clk;

   alu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

   alu_share_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ALU_LAT (ALU_LAT),
      .MAX_MODE(MAX_MODE),
      .CNT_W   (CNT_W)
   ) dut (
      .emu_clk  (emu_clk),
      .emu_rst_n(emu_rst_n),
      .bus      (bus.slave)
   );

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] m);
      case (m)
         8'd0:    return a + b;
         8'd1:    return a - b;
         8'd2:    return a & b;
         8'd3:    return a * b;
         8'd4:    return a >> b;
         8'd5:    return a << b;
         8'd6:    return a | b;
         8'd7:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   // Stand-in ALU: garbage until its inputs have been stable long enough.
   logic [23:0] alu_prev = '0;
   int          alu_age  = 0;
   always @(negedge emu_clk) begin
      if ({bus.a_out, bus.b_out, bus.mode_out} != alu_prev) alu_age <= 0;
      else if (alu_age < 100)                                alu_age <= alu_age + 1;
      alu_prev <= {bus.a_out, bus.b_out, bus.mode_out};
   end
   assign bus.c_in = (alu_age >= ALU_LAT - 1) ? alu_f(bus.a_out, bus.b_out, bus.mode_out)
                                              : ~alu_f(bus.a_out, bus.b_out, bus.mode_out);

   function automatic logic [7:0] byte_of(input logic [VW-1:0] v, input int i);
      logic [VW-1:0] t;
      t = v >> (8 * i);
      return t[7:0];
   endfunction

   function automatic logic [VW-1:0] set_byte(input logic [VW-1:0] v, input int i,
                                              input logic [7:0] x);
      logic [VW-1:0] mask;
      mask = VW'(8'hFF) << (8 * i);
      return (v & ~mask) | (VW'(x) << (8 * i));
   endfunction

   function automatic bit bit_of(input logic [NUM_REQ-1:0] v, input int i);
      logic [NUM_REQ-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   function automatic logic [NUM_REQ-1:0] set_bit(input logic [NUM_REQ-1:0] v, input int i,
                                                 input bit x);
      logic [NUM_REQ-1:0] m;
      m = NUM_REQ'(1) << i;
      return x ? (v | m) : (v & ~m);
   endfunction

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Transaction-level reference state
   int         cyc;
   bit         m_busy;
   int         m_rsp_cyc;
   int         m_last;
   logic [7:0] m_a, m_b, m_mode, m_data;
   int         m_id;
   bit         m_err;
   int         m_cnt;
   int         acc_id;
   int         n_rsp;
   int         grant_q[$];
   int         grant_cyc[$];
   logic [7:0] rsp_q[$];

   task automatic model_reset();
      m_busy = 0; m_last = NUM_REQ - 1;
      m_a = 0; m_b = 0; m_mode = 0; m_data = 0; m_id = 0; m_err = 0; m_cnt = 0;
   endtask

   // One clock cycle: inputs already driven at the falling edge.
   task automatic step();
      int                 w, idx;
      logic [NUM_REQ-1:0] exp_ready;
      bit                 exp_rv;
      logic [7:0]         ma, mb, mm;
      #1;
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (m_last + k) % NUM_REQ;
         if (w < 0 && bit_of(bus.req_valid, idx)) w = idx;
      end
      exp_ready = (!m_busy && emu_rst_n && w >= 0) ? (NUM_REQ'(1) << w) : '0;
      exp_rv    = m_busy && (cyc >= m_rsp_cyc);

      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check_eq("busy", 32'(bus.busy), 32'(m_busy));
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         check_eq("rsp_id", 32'(bus.rsp_id), 32'(m_id));
         check_eq("rsp_data", 32'(bus.rsp_data), 32'(m_data));
         check_eq("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
      check_eq("a_out", 32'(bus.a_out), 32'(m_a));
      check_eq("b_out", 32'(bus.b_out), 32'(m_b));
      check_eq("mode_out", 32'(bus.mode_out), 32'(m_mode));
      check_eq("txn_count", 32'(bus.txn_count), 32'(m_cnt));

      acc_id = -1;
      if (!emu_rst_n) begin
         model_reset();
      end else if (exp_ready != '0) begin
         acc_id = w; m_last = w; m_busy = 1; m_id = w;
         ma = byte_of(bus.req_a, w);
         mb = byte_of(bus.req_b, w);
         mm = byte_of(bus.req_mode, w);
         if (mm <= 8'(MAX_MODE)) begin
            m_a = ma; m_b = mb; m_mode = mm;
            m_data = alu_f(ma, mb, mm); m_err = 0;
            m_rsp_cyc = cyc + 1 + ALU_LAT;
         end else begin
            m_data = 0; m_err = 1;
            m_rsp_cyc = cyc + 1;
         end
         grant_q.push_back(w);
         grant_cyc.push_back(cyc);
      end else if (exp_rv && bus.rsp_ready) begin
         m_cnt  = (m_cnt + 1) % (1 << CNT_W);
         m_busy = 0;
         n_rsp++;
         rsp_q.push_back(bus.rsp_data);
      end
      cyc++;
      @(negedge emu_clk);
   endtask

   task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] m);
      bus.req_valid = set_bit(bus.req_valid, i, 1'b1);
      bus.req_a     = set_byte(bus.req_a, i, a);
      bus.req_b     = set_byte(bus.req_b, i, b);
      bus.req_mode  = set_byte(bus.req_mode, i, m);
   endtask

   initial begin
      logic [7:0] exp_p2 [4];
      exp_p2[0] = 8'd35; exp_p2[1] = 8'd21; exp_p2[2] = 8'd4; exp_p2[3] = 8'd18;
      cyc = 0; n_rsp = 0; acc_id = -1; m_rsp_cyc = 0;
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_mode = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(negedge emu_clk);
      model_reset();
      step();
      emu_rst_n = 1'b1;

      // Single request from requester 0.
      drive_req(0, 8'd12, 8'd34, 8'd0);
      step();
      bus.req_valid = '0;
      repeat (5) step();
      check_eq("p1_rsp_count", 32'(rsp_q.size()), 32'd1);
      if (rsp_q.size() >= 1) check_eq("p1_rsp_data", 32'(rsp_q[0]), 32'd46);

      // All four requesters valid continuously, fresh round-robin pointer.
      emu_rst_n = 1'b0;
      step();
      emu_rst_n = 1'b1;
      grant_q.delete(); grant_cyc.delete(); rsp_q.delete();
      drive_req(0, 8'd45, 8'd10, 8'd1);
      drive_req(1, 8'd3,  8'd7,  8'd3);
      drive_req(2, 8'd9,  8'd1,  8'd4);
      drive_req(3, 8'd9,  8'd1,  8'd5);
      repeat (17) step();
      bus.req_valid = '0;
      repeat (4) step();
      check_eq("p2_grant_count", 32'(grant_q.size()), 32'd5);
      for (int i = 0; i < 5 && i < grant_q.size(); i++)
         check_eq("p2_grant_order", 32'(grant_q[i]), 32'(i % NUM_REQ));
      for (int i = 1; i < grant_cyc.size(); i++)
         check_eq("p2_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'(ALU_LAT + 2));
      for (int i = 0; i < 4 && i < rsp_q.size(); i++)
         check_eq("p2_rsp_data", 32'(rsp_q[i]), 32'(exp_p2[i]));

      // Illegal mode from requester 2.
      drive_req(2, 8'd77, 8'd5, 8'd9);
      step();
      bus.req_valid = '0;
      repeat (3) step();

      // Reset in WAIT aborts; afterwards requester 0 beats requester 3.
      drive_req(1, 8'd50, 8'd60, 8'd0);
      step();
      bus.req_valid = '0;
      step();
      emu_rst_n = 1'b0;
      step();
      emu_rst_n = 1'b1;
      grant_q.delete();
      drive_req(0, 8'd1, 8'd2, 8'd0);
      drive_req(3, 8'd3, 8'd4, 8'd0);
      step();
      bus.req_valid = '0;
      check_eq("p4_first_grant", 32'(grant_q.size() > 0 ? grant_q[0] : -1), 32'd0);
      repeat (5) step();

      // Random traffic with backpressure, drops, illegal modes and resets.
      n_rsp = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_id == i || !bit_of(bus.req_valid, i)) begin
               if ($urandom_range(0, 9) < 4)
                  drive_req(i, 8'($urandom), 8'($urandom_range(0, 9)), 8'($urandom_range(0, 10)));
               else
                  bus.req_valid = set_bit(bus.req_valid, i, 1'b0);
            end else if ($urandom_range(0, 19) == 0) begin
               bus.req_valid = set_bit(bus.req_valid, i, 1'b0);
            end
         end
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
         emu_rst_n     = ($urandom_range(0, 299) != 0);
         step();
      end
      emu_rst_n = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (8) step();
      check_eq("random_traffic", 32'(n_rsp >= 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-bit a/b/mode -> c ALU datapath among NUM_REQ requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Per transaction: latch the winner's operands, drive the ALU, wait ALU_LAT cycles, capture c, return a tagged response.
- Sits between emulator-side test/stimulus sources and the shared ALU instance in the firmware testbench.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LAT, 2, cycles from ALU inputs changing to c being valid (>=1).
- MAX_MODE, 8, highest legal mode code; larger codes are rejected.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- emu_clk  in  1  clock; all logic rising-edge.
- emu_rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  8*NUM_REQ  operand a, requester i at bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand b, same packing.
- req_mode  in  8*NUM_REQ  mode code, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- a_out  out  8  registered ALU operand a.
- b_out  out  8  registered ALU operand b.
- mode_out  out  8  registered ALU mode.
- c_in  in  8  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  clog2(NUM_REQ) (min 1)  index of the served requester.
- rsp_data  out  8  captured ALU result.
- rsp_err  out  1  illegal mode flag.
- busy  out  1  high in any state other than IDLE.
- txn_count  out  CNT_W  completed responses, wraps.

Behaviour:
- Reset (emu_rst_n=0 at a clock edge):
  - State goes to IDLE. a_out, b_out, mode_out, rsp_data, rsp_id, rsp_err, txn_count all 0. rsp_valid=0, req_ready=0, busy=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction aborts it silently: no response, txn_count not incremented.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Winner w = first i with req_valid[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready[w] is asserted combinationally in the same cycle; all other ready bits are 0.
  - The handshake completes that cycle (cycle T). Requester w must hold its operands stable only through T.
  - At the T edge, the block latches req_a/b/mode[w] and sets last=w and rsp_id=w.
  - Legal mode (<=MAX_MODE): a_out, b_out, mode_out are updated; wait counter is loaded with ALU_LAT-1; next state WAIT.
  - Illegal mode: a_out, b_out, mode_out hold their previous values; rsp_err=1, rsp_data=0; next state RESP.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle the counter reads 0, c_in is sampled into rsp_data, rsp_err=0, and the next state is RESP.
  - Result: rsp_valid rises at cycle T+1+ALU_LAT.
  - req_ready stays all 0; new req_valid is ignored and remains pending.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable.
  - On rsp_valid & rsp_ready: txn_count increments (wrapping at 2^CNT_W), next state IDLE, rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle as response retirement. Minimum spacing between accepts is ALU_LAT+2 cycles (illegal mode: 2 cycles) when rsp_ready is tied high.
- Fairness:
  - With all requesters valid continuously, grants cycle 0,1,...,NUM_REQ-1,0,...
  - A requester dropping valid is skipped with no penalty to the others.
- ALU outputs hold their values between transactions; they are not zeroed.
- busy = (state != IDLE).

Test Plan:
- Single request, requester 0: a=12, b=34, mode=0, ALU returns 46 -> req_ready[0] for 1 cycle; a_out/b_out/mode_out = 12/34/0 at T+1; rsp_valid at T+3 (ALU_LAT=2) with rsp_id=0, rsp_data=46, rsp_err=0; txn_count=1.
- All 4 requesters valid continuously with distinct operands (45/10/1, 3/7/3, 9/1/4, 9/1/5), rsp_ready=1 -> grant order 0,1,2,3,0; rsp_data 35, 21, 4, 18 with matching rsp_id; each accept spaced exactly 4 cycles apart.
- Requester 2 sends mode=9 -> rsp_err=1, rsp_data=0 at T+1; a_out/b_out/mode_out unchanged from the previous transaction; txn_count increments.
- Backpressure: rsp_ready=0 for 5 cycles during RESP, with requester 1 valid -> rsp_valid and rsp_data held stable; req_ready stays 0; requester 1 is accepted only in the cycle after rsp_ready=1.
- Reset asserted during WAIT -> next cycle IDLE with all outputs 0; no response; after release, requester 0 wins over requester 3 when both are valid.
- txn_count preloaded near wrap via 2^CNT_W transactions with CNT_W=4 -> 16 responses return txn_count to 0.
